// File: rtl/fetch_sequencer.sv
// Multi-cycle LEGv8 instruction fetch: four little-endian byte reads per word,
// valid/ready delivery to decode, branch redirect, HALT opcode and count limit.
module fetch_sequencer #(
  parameter int          ADDR_W    = 12,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MAX_FETCH = 30,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [63:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_src,
  input  logic [63:0]       branch_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [2:0]  byte_cnt;
  logic [1:0]  req_lane;
  logic        rd_vld_p0;
  logic [1:0]  rd_lane_p0;

  logic [CNT_W-1:0] cnt_next;
  logic             halt_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cnt_next = sat_inc(fetch_count);
  assign halt_hit = (instr[31:21] == 11'h7FF) ||
                    ((MAX_FETCH != 0) && (cnt_next == CNT_W'(MAX_FETCH)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      byte_cnt    <= 3'd0;
      req_lane    <= 2'd0;
      rd_vld_p0   <= 1'b0;
      rd_lane_p0  <= 2'd0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr       <= 32'h0;
      instr_pc    <= 64'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (pc_src) begin
            // Abort: drop the outstanding byte and start the new word next cycle.
            pc        <= branch_addr;
            mem_rd_en <= 1'b1;
            mem_addr  <= branch_addr[ADDR_W-1:0];
            req_lane  <= 2'd0;
            byte_cnt  <= 3'd1;
            rd_vld_p0 <= 1'b0;
          end else begin
            if (byte_cnt < 3'd4) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= pc[ADDR_W-1:0] + ADDR_W'(byte_cnt);
              req_lane  <= byte_cnt[1:0];
              byte_cnt  <= byte_cnt + 3'd1;
            end else begin
              mem_rd_en <= 1'b0;
            end
            // Read-return stage: memory data lags the strobe by one cycle.
            rd_vld_p0  <= mem_rd_en;
            rd_lane_p0 <= req_lane;
            if (rd_vld_p0) begin
              instr[{rd_lane_p0, 3'b000} +: 8] <= mem_rdata;
              if (rd_lane_p0 == 2'd3) begin
                state       <= VALID;
                instr_valid <= 1'b1;
                instr_pc    <= pc;
              end
            end
          end
        end
        VALID: begin
          mem_rd_en <= 1'b0;
          if (instr_ready) begin
            fetch_count <= cnt_next;
            instr_valid <= 1'b0;
            pc          <= pc_src ? branch_addr : pc + 64'd4;
            byte_cnt    <= 3'd0;
            if (halt_hit) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end else if (pc_src) begin
            instr_valid <= 1'b0;
            pc          <= branch_addr;
            byte_cnt    <= 3'd0;
            state       <= FETCH;
          end
        end
        default: begin
          mem_rd_en   <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte-wide IMem model, handshake scoreboard and
// scenario tasks for sequential fetch, backpressure, redirects, halt, limit, reset.
module tb_fetch_sequencer;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr;
  logic [63:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              pc_src;
  logic [63:0]       branch_addr;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  logic              mem_rd_en2;
  logic [ADDR_W-1:0] mem_addr2;
  logic [31:0]       instr2;
  logic [63:0]       instr_pc2;
  logic              instr_valid2;
  logic              halted2;
  logic [CNT_W-1:0]  fetch_count2;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] i; logic [63:0] pc; } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [7:0] imem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(64'h0), .MAX_FETCH(30), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_src(pc_src),
    .branch_addr(branch_addr), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(64'h0), .MAX_FETCH(3), .CNT_W(CNT_W)) dut_lim (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2),
    .mem_rdata(8'h00), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(1'b1), .pc_src(1'b0),
    .branch_addr(64'h0), .halted(halted2), .fetch_count(fetch_count2)
  );

  always @(posedge clk) if (mem_rd_en) mem_rdata <= imem[mem_addr];

  // Scoreboard: every delivered instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL handshake: unexpected instr=%h pc=%h, required no delivery", instr, instr_pc);
      end else begin
        e = sb.pop_front();
        if (instr !== e.i || instr_pc !== e.pc) begin
          fails++;
          $display("FAIL delivery: instr=%h pc=%h, required instr=%h pc=%h", instr, instr_pc, e.i, e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] pc);
    exp_t x;
    x.i = i;
    x.pc = pc;
    sb.push_back(x);
  endtask

  // Follows one word fetch from its first strobe through instr_valid (cycle 5).
  task automatic watch_fetch(input logic [63:0] base, output int waited);
    logic [63:0]       a;
    logic [ADDR_W-1:0] exp_addr;
    waited = 0;
    while (!mem_rd_en && waited < 50) begin
      tick();
      waited++;
    end
    for (int k = 0; k < 4; k++) begin
      a = base + 64'(k);
      exp_addr = a[ADDR_W-1:0];
      tests++;
      if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr) begin
        fails++;
        $display("FAIL fetch_addr[%0d]: rd_en=%b addr=%h, required rd_en=1 addr=%h", k, mem_rd_en, mem_addr, exp_addr);
      end
      tick();
    end
    tests++;
    if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_cycle4: rd_en=%b valid=%b, required 0 0", mem_rd_en, instr_valid);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency: valid=%b in cycle 5, required 1", instr_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (mem_rd_en !== 1'b0 || mem_addr !== '0 || instr !== 32'h0 || instr_pc !== 64'h0 ||
        instr_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== '0) begin
      fails++;
      $display("FAIL %s: rd_en=%b addr=%h instr=%h pc=%h valid=%b halted=%b cnt=%0d, required all zero",
               tag, mem_rd_en, mem_addr, instr, instr_pc, instr_valid, halted, fetch_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_ready = 1'b1;
    pc_src = 1'b0;
    branch_addr = 64'h0;
    repeat (3) tick();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_sequential();
    int w;
    push(32'h8B1F028B, 64'h0);
    push(32'h91000000, 64'h4);
    reset = 1'b0;
    watch_fetch(64'h0, w);
    tests++;
    if (w !== 1) begin
      fails++;
      $display("FAIL first_strobe: %0d cycles after release, required 1", w);
    end
    watch_fetch(64'h4, w);
    tick();
    tests++;
    if (fetch_count !== 16'd2 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL seq_count: cnt=%0d valid=%b, required 2 0", fetch_count, instr_valid);
    end
  endtask

  task automatic test_backpressure_branch();
    int w;
    instr_ready = 1'b0;
    push(32'h12345678, 64'h8);
    watch_fetch(64'h8, w);
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (instr !== 32'h12345678 || instr_pc !== 64'h8 || instr_valid !== 1'b1 ||
          mem_rd_en !== 1'b0 || fetch_count !== 16'd2) begin
        fails++;
        $display("FAIL backpressure[%0d]: instr=%h pc=%h valid=%b rd_en=%b cnt=%0d, required 12345678 8 1 0 2",
                 i, instr, instr_pc, instr_valid, mem_rd_en, fetch_count);
      end
      tick();
    end
    instr_ready = 1'b1;
    pc_src = 1'b1;
    branch_addr = 64'h40;
    tick();
    pc_src = 1'b0;
    tests++;
    if (fetch_count !== 16'd3 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL branch_handshake: cnt=%0d valid=%b, required 3 0", fetch_count, instr_valid);
    end
    push(32'hAABBCCDD, 64'h40);
    watch_fetch(64'h40, w);
  endtask

  task automatic test_abort_wrap();
    int w = 0;
    while (!mem_rd_en && w < 50) begin
      tick();
      w++;
    end
    tests++;
    if (mem_addr !== 12'h044) begin
      fails++;
      $display("FAIL abort_start: addr=%h, required 044", mem_addr);
    end
    tick();
    tick();
    pc_src = 1'b1;
    branch_addr = 64'hFFE;
    tick();
    pc_src = 1'b0;
    push(32'h028B2211, 64'hFFE);
    watch_fetch(64'hFFE, w);
    push(32'h00008B1F, 64'h1002);
    watch_fetch(64'h1002, w);
  endtask

  task automatic test_halt();
    int w;
    pc_src = 1'b1;
    branch_addr = 64'hC;
    tick();
    pc_src = 1'b0;
    push(32'hFFE00000, 64'hC);
    watch_fetch(64'hC, w);
    tests++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_early: halted=%b during delivery, required 0", halted);
    end
    tick();
    tests++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || fetch_count !== 16'd7) begin
      fails++;
      $display("FAIL halt_entry: halted=%b valid=%b rd_en=%b cnt=%0d, required 1 0 0 7",
               halted, instr_valid, mem_rd_en, fetch_count);
    end
    pc_src = 1'b1;
    branch_addr = 64'h40;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || fetch_count !== 16'd7) begin
        fails++;
        $display("FAIL halt_sticky[%0d]: halted=%b valid=%b rd_en=%b cnt=%0d, required 1 0 0 7",
                 i, halted, instr_valid, mem_rd_en, fetch_count);
      end
    end
    pc_src = 1'b0;
  endtask

  task automatic test_limit();
    int w = 0;
    while (!halted2 && w < 200) begin
      tick();
      w++;
    end
    tests++;
    if (halted2 !== 1'b1 || fetch_count2 !== 16'd3 || instr_valid2 !== 1'b0 || mem_rd_en2 !== 1'b0) begin
      fails++;
      $display("FAIL limit: halted=%b cnt=%0d valid=%b rd_en=%b, required 1 3 0 0",
               halted2, fetch_count2, instr_valid2, mem_rd_en2);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_ready = 1'b0;
    while (!mem_rd_en && w < 50) begin
      tick();
      w++;
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    tick();
    reset = 1'b0;
    watch_fetch(64'h0, w);
    tests++;
    if (instr !== 32'h8B1F028B || instr_pc !== 64'h0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_restart: instr=%h pc=%h halted=%b, required 8B1F028B 0 0", instr, instr_pc, halted);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) imem[a] = 8'h00;
    {imem[3], imem[2], imem[1], imem[0]}         = 32'h8B1F028B;
    {imem[7], imem[6], imem[5], imem[4]}         = 32'h91000000;
    {imem[11], imem[10], imem[9], imem[8]}       = 32'h12345678;
    {imem[15], imem[14], imem[13], imem[12]}     = 32'hFFE00000;
    {imem[67], imem[66], imem[65], imem[64]}     = 32'hAABBCCDD;
    {imem[71], imem[70], imem[69], imem[68]}     = 32'h5AC3EE96;
    imem[12'hFFE] = 8'h11;
    imem[12'hFFF] = 8'h22;

    test_reset();
    test_sequential();
    test_backpressure_branch();
    test_abort_wrap();
    test_halt();
    test_limit();
    test_reset_mid();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
